host_mem_emulator: RTL

Cycle-level model of the host shared-memory engine, answering the far end of the `mem_controller` host-side interface (`rd_go`/`rd_en`/`rd_data`/`rd_done`/`empty`, `wr_go`/`wr_en`/`wr_data`/`wr_done`/`full`). It stands in for host DMA in the cache test hierarchy, so the cache–ring–memory path runs self-contained in simulation and on FPGA. It backs a local line-addressed RAM with one read engine, one write engine and a FIFO on each direction.

---
 rtl/host_mem_pkg.sv | 17 +
 rtl/host_mem_emulator_if.sv | 31 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/host_mem_emulator.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/host_mem_pkg.sv
// Shared widths, engine state types and address helper for the host memory emulator.
package host_mem_pkg;

  localparam int unsigned LINE_W   = 512;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned LINE_OFF = 6;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_PUSH} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_COMMIT} wr_state_t;

  // Line number relative to the mapped base; the caller truncates to the RAM index width.
  function automatic logic [ADDR_W-1:0] line_offset(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] base);
    return (addr - base) >> LINE_OFF;
  endfunction

endpackage

// File: rtl/host_mem_emulator_if.sv
// Host-side shared-memory bus between mem_controller (master) and the emulator (slave).
interface host_mem_emulator_if;
  import host_mem_pkg::*;

  logic [ADDR_W-1:0] virt_addr_base;
  logic              rd_go;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [LINE_W-1:0] rd_data;
  logic              empty;
  logic              rd_done;
  logic              wr_go;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [LINE_W-1:0] wr_data;
  logic              full;
  logic              wr_done;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output virt_addr_base, rd_go, rd_addr, rd_en, wr_go, wr_addr, wr_en, wr_data,
    input  rd_data, empty, rd_done, full, wr_done, ovf_err, unf_err
  );

  modport slave (
    input  virt_addr_base, rd_go, rd_addr, rd_en, wr_go, wr_addr, wr_en, wr_data,
    output rd_data, empty, rd_done, full, wr_done, ovf_err, unf_err
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through head (zero when empty) and registered flags.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  // A same-cycle pop makes room for a push even when full.
  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    full_d  = (cnt_d == CntW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = empty_q ? '0 : mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/host_mem_emulator.sv
// Host DMA stand-in: line-addressed RAM behind one read engine and one write engine,
// each decoupled from the bus by a FIFO.
module host_mem_emulator
  import host_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LINES = 256,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned RD_LATENCY  = 4
) (
  input logic                clk,
  input logic                rst,
  host_mem_emulator_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_LINES);
  localparam int unsigned LatW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  rd_state_t         rd_state_q, rd_state_d;
  logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic              rd_done_q, rd_done_d;
  logic [LINE_W-1:0] line_q;

  wr_state_t         wr_state_q, wr_state_d;
  logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
  logic              wr_done_q, wr_done_d;

  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic [LINE_W-1:0] ram_q [DEPTH_LINES];

  logic              rf_push, rf_full, rf_empty;
  logic [LINE_W-1:0] rf_data;
  logic [CntW-1:0]   rf_count;
  logic              wf_push, wf_full, wf_empty;
  logic [LINE_W-1:0] wf_data;
  logic [CntW-1:0]   wf_count;
  logic              unused_count;

  logic              rd_sample, wr_commit;

  assign unused_count = ^{rf_count, wf_count};

  assign rd_sample = (rd_state_q == R_WAIT) && (lat_q == LatW'(RD_LATENCY - 1));
  assign rf_push   = (rd_state_q == R_PUSH) && (!rf_full || bus.rd_en);
  assign wr_commit = rst && (wr_state_q == W_DATA) && !wf_empty;
  // External writers see only the registered full flag; a same-cycle commit does not help.
  assign wf_push   = bus.wr_en && !wf_full;

  sync_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (rf_push),
    .data_i  (line_q),
    .pop_i   (bus.rd_en),
    .data_o  (rf_data),
    .full_o  (rf_full),
    .empty_o (rf_empty),
    .count_o (rf_count)
  );

  sync_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (wf_push),
    .data_i  (bus.wr_data),
    .pop_i   (wr_commit),
    .data_o  (wf_data),
    .full_o  (wf_full),
    .empty_o (wf_empty),
    .count_o (wf_count)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    lat_d      = lat_q;
    rd_done_d  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (bus.rd_go) begin
          rd_state_d = R_WAIT;
          rd_idx_d   = IdxW'(line_offset(bus.rd_addr, bus.virt_addr_base));
          lat_d      = '0;
        end
      end
      R_WAIT: begin
        if (rd_sample) rd_state_d = R_PUSH;
        else           lat_d      = lat_q + 1'b1;
      end
      R_PUSH: begin
        if (rf_push) begin
          rd_state_d = R_IDLE;
          rd_done_d  = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // W_COMMIT is the wr_done cycle; it takes a new wr_go like W_IDLE so requests can chain.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_done_d  = 1'b0;
    unique case (wr_state_q)
      W_IDLE, W_COMMIT: begin
        wr_state_d = W_IDLE;
        if (bus.wr_go) begin
          wr_state_d = W_DATA;
          wr_idx_d   = IdxW'(line_offset(bus.wr_addr, bus.virt_addr_base));
        end
      end
      W_DATA: begin
        if (wr_commit) begin
          wr_state_d = W_COMMIT;
          wr_done_d  = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q | (bus.wr_en && wf_full);
    unf_d = unf_q | (bus.rd_en && rf_empty)
                  | (bus.rd_go && (rd_state_q != R_IDLE))
                  | (bus.wr_go && (wr_state_q == W_DATA));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state_q <= R_IDLE;
      rd_idx_q   <= '0;
      lat_q      <= '0;
      rd_done_q  <= 1'b0;
      wr_state_q <= W_IDLE;
      wr_idx_q   <= '0;
      wr_done_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      lat_q      <= lat_d;
      rd_done_q  <= rd_done_d;
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_done_q  <= wr_done_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // A commit to the line being sampled on the same edge is forwarded to the read.
  always_ff @(posedge clk) begin
    if (wr_commit) ram_q[wr_idx_q] <= wf_data;
    if (rd_sample) begin
      line_q <= (wr_commit && (wr_idx_q == rd_idx_q)) ? wf_data : ram_q[rd_idx_q];
    end
  end

  assign bus.rd_data = rf_data;
  assign bus.empty   = rf_empty;
  assign bus.rd_done = rd_done_q;
  assign bus.full    = wf_full;
  assign bus.wr_done = wr_done_q;
  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;

endmodule
